// File: rtl/count_ctrl.sv
// Push-button step controller: debounces a two-button code and emits up/down step pulses.
// Holding a button auto-repeats; with auto sweep enabled, an idle controller steps up periodically.
`timescale 1ns/1ps
module count_ctrl #(
  parameter int unsigned DEB_CNT  = 500000,
  parameter int unsigned REP_DLY  = 25000000,
  parameter int unsigned REP_PER  = 5000000,
  parameter int unsigned AUTO_PER = 50000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [1:0] i_Push,
  input  logic       i_AutoEn,
  output logic       o_Up,
  output logic       o_Dn,
  output logic [1:0] o_State,
  output logic       o_Busy
);
  localparam int unsigned TW = 26;

  localparam logic [TW-1:0] DEB_LAST  = TW'(DEB_CNT - 1);
  localparam logic [TW-1:0] DLY_LAST  = TW'(REP_DLY - 1);
  localparam logic [TW-1:0] PER_LAST  = TW'(REP_PER - 1);
  localparam logic [TW-1:0] AUTO_LAST = TW'(AUTO_PER - 1);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_DN   = 2'b01;
  localparam logic [1:0] CODE_UP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    RPT  = 2'd2
  } state_t;

  logic [1:0]    sync1, sync2;
  logic [1:0]    push_p;
  logic [1:0]    cand;
  logic [1:0]    deb;
  logic [TW-1:0] deb_cnt;

  state_t        state;
  logic [1:0]    cap;
  logic [TW-1:0] tmr;
  logic          auto_q;

  // Buttons are active-low; the synchronizer idles at "released".
  assign push_p  = ~sync2;
  assign o_State = state;

  // Synchronize, then accept a new code only after it has stayed unchanged long enough.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      cand    <= CODE_NONE;
      deb     <= CODE_NONE;
      deb_cnt <= '0;
    end else begin
      sync1 <= i_Push;
      sync2 <= sync1;
      if (push_p != cand) begin
        cand    <= push_p;
        deb_cnt <= '0;
      end else if (cand != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= cand;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + TW'(1);
        end
      end
    end
  end

  // Step FSM; the shared timer is the auto-sweep period in IDLE and the repeat timer otherwise.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state  <= IDLE;
      cap    <= CODE_NONE;
      tmr    <= '0;
      auto_q <= 1'b0;
      o_Up   <= 1'b0;
      o_Dn   <= 1'b0;
      o_Busy <= 1'b0;
    end else begin
      o_Up   <= 1'b0;
      o_Dn   <= 1'b0;
      auto_q <= i_AutoEn;
      unique case (state)
        IDLE: begin
          if (deb == CODE_UP || deb == CODE_DN) begin
            {o_Up, o_Dn} <= deb;
            cap          <= deb;
            tmr          <= '0;
            state        <= DLY;
            o_Busy       <= 1'b1;
          end else if (deb == CODE_NONE && auto_q) begin
            if (tmr == AUTO_LAST) begin
              o_Up <= 1'b1;
              tmr  <= '0;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end else begin
            tmr <= '0;
          end
        end
        DLY: begin
          if (deb != cap) begin
            state  <= IDLE;
            tmr    <= '0;
            o_Busy <= 1'b0;
          end else if (tmr == DLY_LAST) begin
            {o_Up, o_Dn} <= cap;
            tmr          <= '0;
            state        <= RPT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        RPT: begin
          if (deb != cap) begin
            state  <= IDLE;
            tmr    <= '0;
            o_Busy <= 1'b0;
          end else if (tmr == PER_LAST) begin
            {o_Up, o_Dn} <= cap;
            tmr          <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tmr    <= '0;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
